// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add multiplier: one 31-bit ripple add-with-carry per RUN cycle,
// operands in and product out through valid/ready handshakes.
module mult_seq_ctrl #(
    parameter int W          = 15,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [2*W-1:0] product_o,
    output logic [3:0]     cycles_o,
    output logic           busy_o,
    output logic [1:0]     state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // out_valid_o holds with a stable product until out_ready_i is seen.

    localparam int          AW = 31;
    localparam logic [3:0]  W4 = 4'(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [AW-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]     b_sh_q, b_sh_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [2*W-1:0]   product_q, product_d;
    logic [3:0]       cycles_q, cycles_d;

    logic [AW-1:0]    addend;
    logic [AW-1:0]    sum;
    logic [AW:0]      carry;
    logic             add_co;
    logic [W-1:0]     b_sh_next;
    logic [3:0]       cnt_inc;

    assign addend   = b_sh_q[0] ? a_sh_q : '0;
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < AW; i++) begin : g_fa
        assign sum[i]     = acc_q[i] ^ addend[i] ^ carry[i];
        assign carry[i+1] = (acc_q[i] & addend[i]) | (carry[i] & (acc_q[i] ^ addend[i]));
    end

    assign add_co    = carry[AW];
    assign b_sh_next = b_sh_q >> 1;
    assign cnt_inc   = cnt_q + 4'd1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
            cycles_q    <= cycles_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        product_d   = product_q;
        cycles_d    = cycles_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    acc_d  = '0;
                    a_sh_d = {{(AW-W){1'b0}}, a_i};
                    b_sh_d = b_i;
                    cnt_d  = '0;
                    if (EARLY_EXIT && (b_i == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d  = sum;
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_next;
                cnt_d  = cnt_inc;
                if ((cnt_inc == W4) || (EARLY_EXIT && (b_sh_next == '0))) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    product_d   = sum[2*W-1:0];
                    cycles_d    = cnt_inc;
                end
            end
            DONE: begin
                // A zero multiplier arrives here straight from IDLE; publish its result
                // one cycle later so every product takes at least one edge.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    product_d   = acc_q[2*W-1:0];
                    cycles_d    = cnt_q;
                end else if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q == RUN) || (state_q == DONE);
    assign out_valid_o = out_valid_q;
    assign product_o   = product_q;
    assign cycles_o    = cycles_q;
    assign state_o     = state_q;

    // With W <= 15 the running sum stays below 2^30, so the adder never carries out.
    a_no_carry_out: assert property (@(posedge clk_i) disable iff (reset_i)
        (state_q == RUN) |-> !add_co);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: one early-exit instance (index 0) and one
// fixed-length instance (index 1), checked against hand-computed products and latencies.
module tb_mult_seq_ctrl;

    localparam int W = 15;

    logic           clk;
    logic           reset;
    logic           in_valid  [2];
    logic           in_ready  [2];
    logic [W-1:0]   a         [2];
    logic [W-1:0]   b         [2];
    logic           out_valid [2];
    logic           out_ready [2];
    logic [2*W-1:0] product   [2];
    logic [3:0]     cycles    [2];
    logic           busy      [2];
    logic [1:0]     state     [2];

    int n_checks = 0;
    int n_errors = 0;

    mult_seq_ctrl #(.W(W), .EARLY_EXIT(1'b1)) u_dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (in_valid[0]),
        .in_ready_o  (in_ready[0]),
        .a_i         (a[0]),
        .b_i         (b[0]),
        .out_valid_o (out_valid[0]),
        .out_ready_i (out_ready[0]),
        .product_o   (product[0]),
        .cycles_o    (cycles[0]),
        .busy_o      (busy[0]),
        .state_o     (state[0])
    );

    mult_seq_ctrl #(.W(W), .EARLY_EXIT(1'b0)) u_dut_fixed (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (in_valid[1]),
        .in_ready_o  (in_ready[1]),
        .a_i         (a[1]),
        .b_i         (b[1]),
        .out_valid_o (out_valid[1]),
        .out_ready_i (out_ready[1]),
        .product_o   (product[1]),
        .cycles_o    (cycles[1]),
        .busy_o      (busy[1]),
        .state_o     (state[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one operand pair on instance sel, measure latency, check result, then consume it.
    task automatic run_op(input int sel, input string tag,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [31:0] exp_prod, input logic [31:0] exp_cyc,
                          input int exp_lat);
        int lat;
        logic ready_leak;
        @(negedge clk);
        check({tag, "_ready_before"}, 32'(in_ready[sel]), 32'd1);
        in_valid[sel] = 1'b1;
        a[sel]        = av;
        b[sel]        = bv;
        @(posedge clk);
        @(negedge clk);
        in_valid[sel] = 1'b0;
        lat        = 0;
        ready_leak = 1'b0;
        while (!out_valid[sel] && lat < 40) begin
            if (in_ready[sel]) ready_leak = 1'b1;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_ready_low_run"}, 32'(ready_leak), 32'd0);
        check({tag, "_product"}, 32'(product[sel]), exp_prod);
        check({tag, "_cycles"}, 32'(cycles[sel]), exp_cyc);
        check({tag, "_busy_done"}, 32'(busy[sel]), 32'd1);
        check({tag, "_ready_done"}, 32'(in_ready[sel]), 32'd0);
        out_ready[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[sel] = 1'b0;
        check({tag, "_valid_after"}, 32'(out_valid[sel]), 32'd0);
        check({tag, "_ready_after"}, 32'(in_ready[sel]), 32'd1);
        check({tag, "_busy_after"}, 32'(busy[sel]), 32'd0);
        check({tag, "_product_hold"}, 32'(product[sel]), exp_prod);
    endtask

    initial begin
        logic flag;
        int   lat;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            a[i]         = '0;
            b[i]         = '0;
        end

        @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(in_ready[0]), 32'd1);
        check("rst_valid", 32'(out_valid[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_product", 32'(product[0]), 32'd0);
        check("rst_cycles", 32'(cycles[0]), 32'd0);
        check("rst_state", 32'(state[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op(0, "basic", 15'd6, 15'd7, 32'd42, 32'd3, 3);
        run_op(0, "max", 15'd32767, 15'd32767, 32'd1073676289, 32'd15, 15);
        run_op(0, "zero_b", 15'd123, 15'd0, 32'd0, 32'd0, 1);
        run_op(1, "fixed_zero_b", 15'd123, 15'd0, 32'd0, 32'd15, 15);
        run_op(1, "fixed_one", 15'd1, 15'd1, 32'd1, 32'd15, 15);
        run_op(0, "top_bit", 15'd1, 15'h4000, 32'd16384, 32'd15, 15);

        // Backpressure: result held while a new pair is offered and must be ignored.
        @(negedge clk);
        in_valid[0] = 1'b1;
        a[0]        = 15'd5;
        b[0]        = 15'd9;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd4);
        flag = 1'b0;
        in_valid[0] = 1'b1;
        a[0]        = 15'd1;
        b[0]        = 15'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!out_valid[0] || in_ready[0] || product[0] != 30'd45 || cycles[0] != 4'd4)
                flag = 1'b1;
        end
        in_valid[0] = 1'b0;
        check("bp_stable", 32'(flag), 32'd0);
        check("bp_product", 32'(product[0]), 32'd45);
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("bp_ready_after", 32'(in_ready[0]), 32'd1);
        check("bp_valid_after", 32'(out_valid[0]), 32'd0);
        check("bp_product_hold", 32'(product[0]), 32'd45);
        @(posedge clk);
        @(negedge clk);
        check("bp_not_accepted", 32'(in_ready[0]), 32'd1);

        // Reset two edges into a long RUN discards the operation.
        @(negedge clk);
        in_valid[0] = 1'b1;
        a[0]        = 15'd3;
        b[0]        = 15'h4000;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        check("mid_busy", 32'(busy[0]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_ready", 32'(in_ready[0]), 32'd1);
        check("mid_rst_product", 32'(product[0]), 32'd0);
        check("mid_rst_cycles", 32'(cycles[0]), 32'd0);
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid[0]) flag = 1'b1;
        end
        check("mid_no_valid", 32'(flag), 32'd0);
        run_op(0, "after_rst", 15'd2, 15'd3, 32'd6, 32'd2, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
